// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// word/address types and the reset/bubble constants.
package fetch_unit_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam word_t NOP_WORD         = 32'h0000_0000;
    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

    // Branch targets are forced onto a word boundary before use.
    function automatic word_t alignWord(input word_t a);
        return a & ~word_t'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_ack;
    word_t imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack bus, parks a
// returned word while stalled and redirects on taken branches.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               staller_i,
    input  logic               branch_taken_i,
    input  word_t              branch_target_i,
    fetch_unit_if.master       imem,
    output word_t              PC_out_o,
    output word_t              idata_out_o,
    output logic               fetch_valid_o
);

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        hold_data_q, hold_data_d;
    word_t        redir_pc_q, redir_pc_d;

    word_t target;
    word_t pc_plus4;

    assign target   = alignWord(branch_target_i);
    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            hold_data_q <= '0;
            redir_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_data_q <= hold_data_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hold_data_d    = hold_data_q;
        redir_pc_d     = redir_pc_q;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        idata_out_o    = NOP_WORD;
        PC_out_o       = '0;
        fetch_valid_o  = 1'b0;

        unique case (state_q)
            FETCH: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    if (branch_taken_i) begin
                        pc_d = target;
                    end else if (staller_i) begin
                        hold_data_d = imem.imem_rdata;
                        state_d     = HOLD;
                    end else begin
                        idata_out_o   = imem.imem_rdata;
                        PC_out_o      = pc_plus4;
                        fetch_valid_o = 1'b1;
                        pc_d          = pc_plus4;
                    end
                end else if (branch_taken_i) begin
                    // The request address must not move until its ack, so the
                    // redirect waits in redir_pc while the response is thrown away.
                    redir_pc_d = target;
                    state_d    = DISCARD;
                end
            end

            HOLD: begin
                idata_out_o   = hold_data_q;
                PC_out_o      = pc_plus4;
                fetch_valid_o = 1'b1;
                if (branch_taken_i) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!staller_i) begin
                    pc_d    = pc_plus4;
                    state_d = FETCH;
                end
            end

            DISCARD: begin
                imem.imem_req = 1'b1;
                if (branch_taken_i) begin
                    redir_pc_d = target;
                end
                if (imem.imem_ack) begin
                    pc_d    = branch_taken_i ? target : redir_pc_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        // The memory shares this reset, so nothing may be requested or emitted while it is held.
        if (rst) begin
            imem.imem_req = 1'b0;
            idata_out_o   = NOP_WORD;
            PC_out_o      = '0;
            fetch_valid_o = 1'b0;
        end
    end

endmodule
